rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter sharing one resource (e.g. a memory or ALU port) among four clients.
- The winner index is registered. The one-hot grant vector is produced by the existing decoder_2to4 block.
- A grant is held until the owner releases it.
- Sits between requester FSMs and the shared datapath. Sequences ownership changes without bubbles when contention exists.

Parameters:
- MAX_HOLD, 16: maximum cycles one owner may hold the grant. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  Single clock. All state updates on rising edge.
- reset  input  1  Synchronous, active-high reset.
- req  input  4  Request vector. req[i] is held high while client i wants the resource.
- release  input  1  Owner signals done. Sampled only while grant_valid=1.
- grant  output  4  One-hot grant. All zero when no owner.
- grant_id  output  2  Encoded owner index. Valid only when grant_valid=1.
- grant_valid  output  1  The resource is owned this cycle.
- timeout  output  1  One-cycle pulse when a grant is revoked. Present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset values:
  - grant=4'b0000, grant_id=2'b00, grant_valid=0, timeout=0.
  - Priority pointer last=2'b11, so req[0] wins first.
  - Hold counter=0, FSM=IDLE.
- FSM has two states, IDLE and OWNED.
- IDLE:
  - If req!=0, search from (last+1) mod 4 upward with wrap, and select the first set bit.
  - Next cycle: grant_id=winner, grant_valid=1, last=winner, state=OWNED.
  - Latency from req rise to grant is exactly 1 cycle.
  - If req==0, remain in IDLE with outputs zero.
- OWNED:
  - The grant is held while req[grant_id]=1 and release=0. Arrival of other requests has no effect.
  - End-of-ownership occurs when release=1, or when req[grant_id]=0 (a dropped request is treated as an implicit release).
  - On end-of-ownership, if another request is pending (req masked by the current owner is nonzero), select the next winner starting at (grant_id+1) mod 4. The grant switches on the next edge with no idle cycle, and the state stays OWNED.
  - On end-of-ownership with nothing else pending, go to IDLE; grant_valid=0 next cycle.
  - If the releasing owner also keeps req high together with release, it is treated as pending. It regains the grant only after every other pending requester has been served (the round-robin rule).
- grant always equals decode(grant_id) gated by grant_valid. It is never non-one-hot and never nonzero while grant_valid=0.
- Hold counter:
  - Clears on every new grant.
  - Increments each OWNED cycle.
  - Saturates at 2^CNT_W-1.
- Reset asserted mid-ownership: outputs return to reset values on the next edge, regardless of req or release.
- release while grant_valid=0 is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - If the hold counter reaches MAX_HOLD-1 while still OWNED and no release occurs, the grant is revoked on the next edge.
  - timeout pulses high for that single cycle.
  - The revoked client loses priority: next winner search starts at (grant_id+1) mod 4.
  - If no other requester is pending, go to IDLE for at least one cycle before the revoked client can be re-granted.
- When undefined:
  - No timeout port.
  - Grants are unbounded.
  - The counter logic may be removed.

Decomposition:
- Shared package (arb_pkg):
  - State encoding localparams ST_IDLE=1'b0 and ST_OWNED=1'b1.
  - NUM_REQ=4.
  - Index width ID_W=2.
- Sub-module: the existing decoder_2to4 (ports code, out), instantiated once to map grant_id to the one-hot vector, which is then ANDed with grant_valid.
- The wrap-around priority search stays in a combinational function inside rr_arbiter_4.

Test Plan:
- Reset then req=4'b0001: next cycle grant=4'b0001, grant_id=0, grant_valid=1. Release is pulsed with req=0, and grant returns to 0000 the following cycle.
- req=4'b1111 held, release pulsed each cycle: grants cycle 0001→0010→0100→1000→0001 with no idle cycle between them.
- Owner 2 granted, req[0] rises mid-ownership: grant stays 0100 until release. The next winner is id 3 if req[3]=1, otherwise id 0.
- Owner 1 drops req[1] without release while req=4'b0100: grant moves to 0100 next cycle (implicit release).
- Reset asserted while grant=1000: next edge gives grant=0000 and grant_valid=0. Then req=4'b1001 grants 0001 first (pointer reset to 3).
- With ARB_TIMEOUT_EN and MAX_HOLD=16: client 0 holds with no release and req=4'b0011. After 16 owned cycles, timeout pulses for 1 cycle and grant moves to 0010.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
//   NUM_REQ  : number of requesting clients
//   ID_W     : width of the encoded owner index
//   state_t  : arbiter FSM state (IDLE / OWNED)
package arb_pkg;

  localparam int   NUM_REQ  = 4;
  localparam int   ID_W     = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OWNED = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    OWNED = ST_OWNED
  } state_t;

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder.
//   code : 2-bit binary index
//   out  : one-hot vector with bit[code] set
module decoder_2to4 (
  input  logic [1:0] code,
  output logic [3:0] out
);

  assign out = 4'b0001 << code;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter for one shared resource.
// The owner index is registered; the one-hot grant is decoded from it.
// A grant is held until the owner releases it or drops its request, and
// ownership passes straight to the next pending client with no idle cycle.
//
// Optional feature, macro ARB_TIMEOUT_EN: an owner holding for MAX_HOLD
// cycles without releasing is revoked and the timeout port pulses.
//
// Ports:
//   clk           : clock, rising edge
//   reset         : synchronous, active-high reset
//   req[3:0]      : request vector, held high while a client wants access
//   owner_release : owner done strobe (the word "release" is reserved in
//                   SystemVerilog); ignored while grant_valid=0
//   grant[3:0]    : one-hot grant, zero when there is no owner
//   grant_id[1:0] : encoded owner, meaningful only when grant_valid=1
//   grant_valid   : resource is owned this cycle
//   timeout       : one-cycle revoke pulse (ARB_TIMEOUT_EN only)
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no owner; search req from last+1 each cycle
// OWNED | grant_id owns the resource until end of ownership
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               owner_release,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  state_t             state;
  logic [ID_W-1:0]    last;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] pending;
  logic [ID_W-1:0]    idle_pick;
  logic [ID_W-1:0]    next_pick;
  logic               end_own;
  logic               revoke;

  // First set bit of r at or after start, wrapping. Scanning the offsets in
  // descending order lets the smallest offset overwrite the result last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    start);
    logic [ID_W-1:0] idx;
    rr_pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + ID_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  decoder_2to4 u_dec (
    .code (grant_id),
    .out  (owner_onehot)
  );

  assign grant     = owner_onehot & {NUM_REQ{grant_valid}};
  // The current owner is excluded, so a releasing owner that keeps req high
  // waits until everyone else pending has been served.
  assign pending   = req & ~owner_onehot;
  // A dropped request counts as an implicit release.
  assign end_own   = owner_release | ~req[grant_id];
  assign idle_pick = rr_pick(req, last + 2'd1);
  assign next_pick = rr_pick(pending, grant_id + 2'd1);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  assign revoke = ~end_own & (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign revoke = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 2'b11;
      grant_id    <= '0;
      grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id    <= idle_pick;
            last        <= idle_pick;
            grant_valid <= 1'b1;
            state       <= OWNED;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        OWNED: begin
          if (end_own || revoke) begin
`ifdef ARB_TIMEOUT_EN
            timeout <= revoke;
`endif
            if (|pending) begin
              grant_id <= next_pick;
              last     <= next_pick;
`ifdef ARB_TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end else begin
              // last keeps the old owner, so after a revoke the client
              // sees one idle cycle before it can win again.
              state       <= IDLE;
              grant_valid <= 1'b0;
              grant_id    <= '0;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       owner_release = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic [1:0] id;
    logic       valid;
    logic       chk_id;
    logic       to;
  } exp_t;

  exp_t sb[$];

  rr_arbiter_4 #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .owner_release (owner_release),
    .grant         (grant),
    .grant_id      (grant_id),
    .grant_valid   (grant_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout       (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string what,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b", name, what, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the output expected after the edge.
  task automatic step(input string name, input logic rst, input logic [3:0] r,
                      input logic rl, input logic [3:0] eg, input logic [1:0] eid,
                      input logic ev, input logic eto);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    req           = r;
    owner_release = rl;
    e.name   = name;
    e.grant  = eg;
    e.id     = eid;
    e.valid  = ev;
    e.chk_id = ev | rst;
    e.to     = eto;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "grant", grant, e.grant);
        chk(e.name, "grant_valid", {3'b000, grant_valid}, {3'b000, e.valid});
        if (e.chk_id) chk(e.name, "grant_id", {2'b00, grant_id}, {2'b00, e.id});
`ifdef ARB_TIMEOUT_EN
        chk(e.name, "timeout", {3'b000, timeout}, {3'b000, e.to});
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    //    name          rst  req     rel   grant    id     v     to
    step("reset0",     1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("reset1",     1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("first_gnt",  1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rel_idle",   1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rel_ignore", 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("all_req",    1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("all_hold",   1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_2",       1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_3",       1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_wrap0",   1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_1",       1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("own2",       1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("own2_req0",  1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("own2_req3",  1'b0, 4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("own2_to3",   1'b0, 4'b1101, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("drop3_to0",  1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("to1",        1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("drop1_to2",  1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("hold2",      1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("own2_to0",   1'b0, 4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("self_idle",  1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("self_again", 1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("self_yield", 1'b0, 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("to3",        1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("mid_reset",  1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("ptr_reset",  1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("ptr_next3",  1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("drop_idle",  1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    step("to_reset",   1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      step("to_hold",  1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("to_revoke",  1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1);
    step("to_after",   1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
